// File: rtl/ring_pkg.sv
// ring_pkg: shared types and helpers for the one-hot ring decoder.
//   ring_state_t - sequence monitor state (HUNT / LOCKED)
//   rot_r/rot_l  - one-step ring rotations over the low w bits of a word
//                  padded to RING_MAX_W; bits at and above w come back zero.
package ring_pkg;

  localparam int RING_WIDTH_DEF    = 4;
  localparam int RING_LOCK_CNT_DEF = 2;
  localparam int RING_MAX_W        = 64;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} ring_state_t;

  // Right rotation: bit i takes bit i+1, the top bit takes bit 0.
  function automatic logic [RING_MAX_W-1:0] rot_r(input logic [RING_MAX_W-1:0] v,
                                                  input int w);
    logic [RING_MAX_W:0]   vx;
    logic [RING_MAX_W-1:0] o;
    vx = {1'b0, v};
    o  = '0;
    for (int i = 0; i < RING_MAX_W; i++) begin
      if (i == w - 1)    o[i] = v[0];
      else if (i < w - 1) o[i] = vx[i+1];
    end
    return o;
  endfunction

  // Left rotation: bit i takes bit i-1, bit 0 takes the top bit.
  function automatic logic [RING_MAX_W-1:0] rot_l(input logic [RING_MAX_W-1:0] v,
                                                  input int w);
    logic [RING_MAX_W-1:0] o;
    o = '0;
    for (int i = 1; i < RING_MAX_W; i++) begin
      if (i < w) o[i] = v[i-1];
    end
    for (int j = 0; j < RING_MAX_W; j++) begin
      if (j == w - 1) o[0] = v[j];
    end
    return o;
  endfunction

endpackage

// File: rtl/ring_decoder_onehot_enc.sv
// onehot_enc: combinational one-hot check and binary encoder.
//   ring  [WIDTH]          - word to inspect
//   idx   [$clog2(WIDTH)]  - position of the set bit (valid when legal)
//   legal                  - exactly one bit set
module onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = RING_WIDTH_DEF,
  localparam int IW   = $clog2(WIDTH),
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] ring,
  output logic [IW-1:0]    idx,
  output logic             legal
);

  logic [CW-1:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring[i]) begin
        w_cnt = w_cnt + CW'(1);
        idx   = IW'(i);
      end
    end
    legal = (w_cnt == CW'(1));
  end

endmodule

// File: rtl/ring_decoder.sv
// ring_decoder: decoder and sequence monitor for a one-hot ring counter.
//   clk, rst (sync, active low)
//   ring [WIDTH], ring_vld       - sampled word and its qualifier
//   idx, onehot_ok               - hot-bit index / legality of last sample
//   locked, seq_err, err_cnt     - lock status, error pulse, saturating count
// Optional: RING_DECODER_BIDIR_EN adds output dir (0=right, 1=left) and
// accepts either rotation direction, locking onto whichever one is seen.
// All outputs are registered, one cycle after the sampling edge.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH    = RING_WIDTH_DEF,
  parameter int LOCK_CNT = RING_LOCK_CNT_DEF,
  parameter int ERR_W    = 8,
  localparam int IW      = $clog2(WIDTH),
  localparam int GW      = $clog2(LOCK_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ring,
  input  logic             ring_vld,
  output logic [IW-1:0]    idx,
  output logic             onehot_ok,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
`ifdef RING_DECODER_BIDIR_EN
  ,
  output logic             dir
`endif
);

  ring_state_t      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_prev, w_prev_nxt;
  logic             r_prev_vld, w_prev_vld_nxt;
  logic [GW-1:0]    r_good, w_good_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic             r_ok, w_ok_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_seq_err, w_seq_err_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;

  logic [IW-1:0]    w_idx;
  logic             w_legal;
  logic             w_match_r, w_match_l;
  logic             w_hit;   // legal step in the currently accepted direction
  logic             w_opp;   // legal step in the other direction (bidir only)

  onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .ring  (ring),
    .idx   (w_idx),
    .legal (w_legal)
  );

  // Compare at full padded width so every function output bit is consumed.
  assign w_match_r = (rot_r(RING_MAX_W'(r_prev), WIDTH) == RING_MAX_W'(ring));
  assign w_match_l = (rot_l(RING_MAX_W'(r_prev), WIDTH) == RING_MAX_W'(ring));

`ifdef RING_DECODER_BIDIR_EN
  logic r_dir, w_dir_nxt;
  assign w_hit = r_prev_vld && w_legal && (r_dir ? w_match_l : w_match_r);
  assign w_opp = r_prev_vld && w_legal && (r_dir ? w_match_r : w_match_l);
  assign dir   = r_dir;
`else
  assign w_hit = r_prev_vld && w_legal && w_match_r;
  assign w_opp = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_prev_nxt     = r_prev;
    w_prev_vld_nxt = r_prev_vld;
    w_good_nxt     = r_good;
    w_idx_nxt      = r_idx;
    w_ok_nxt       = r_ok;
    w_locked_nxt   = r_locked;
    w_seq_err_nxt  = 1'b0;
    w_err_nxt      = r_err;
`ifdef RING_DECODER_BIDIR_EN
    w_dir_nxt      = r_dir;
`endif
    if (ring_vld) begin
      w_ok_nxt = w_legal;
      if (w_legal) w_idx_nxt = w_idx;
      case (r_state)
        HUNT: begin
          if (!w_legal) begin
            w_good_nxt     = '0;
            w_prev_vld_nxt = 1'b0;
          end else begin
            w_prev_nxt     = ring;
            w_prev_vld_nxt = 1'b1;
            if (w_hit) begin
              w_good_nxt = r_good + GW'(1);
            end else if (w_opp) begin
              // Reversal (or first step seen leftwards): adopt the new direction.
              w_good_nxt = GW'(1);
`ifdef RING_DECODER_BIDIR_EN
              w_dir_nxt  = ~r_dir;
`endif
            end else begin
              w_good_nxt = '0;
            end
            if (w_good_nxt == GW'(LOCK_CNT)) begin
              w_state_nxt  = LOCKED;
              w_locked_nxt = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (w_hit) begin
            w_prev_nxt = ring;
          end else begin
            w_seq_err_nxt = 1'b1;
            if (r_err != '1) w_err_nxt = r_err + ERR_W'(1);
            w_state_nxt   = HUNT;
            w_locked_nxt  = 1'b0;
            w_good_nxt    = '0;
            if (w_legal) begin
              w_prev_nxt     = ring;
              w_prev_vld_nxt = 1'b1;
            end else begin
              w_prev_vld_nxt = 1'b0;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= HUNT;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_good     <= '0;
      r_idx      <= '0;
      r_ok       <= 1'b0;
      r_locked   <= 1'b0;
      r_seq_err  <= 1'b0;
      r_err      <= '0;
`ifdef RING_DECODER_BIDIR_EN
      r_dir      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= w_prev_nxt;
      r_prev_vld <= w_prev_vld_nxt;
      r_good     <= w_good_nxt;
      r_idx      <= w_idx_nxt;
      r_ok       <= w_ok_nxt;
      r_locked   <= w_locked_nxt;
      r_seq_err  <= w_seq_err_nxt;
      r_err      <= w_err_nxt;
`ifdef RING_DECODER_BIDIR_EN
      r_dir      <= w_dir_nxt;
`endif
    end
  end

  assign idx       = r_idx;
  assign onehot_ok = r_ok;
  assign locked    = r_locked;
  assign seq_err   = r_seq_err;
  assign err_cnt   = r_err;

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed-vector bench for ring_decoder (WIDTH=4, LOCK_CNT=2).
// u_dut uses ERR_W=8; u_sat shares the stimulus with ERR_W=2 to exercise
// counter saturation. Build with RING_DECODER_BIDIR_EN to cover dir.
module tb_ring_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] ring = '0;
  logic       ring_vld = 1'b0;

  logic [1:0] idx,  s_idx;
  logic       ok,   s_ok;
  logic       lk,   s_lk;
  logic       se,   s_se;
  logic [7:0] ec;
  logic [1:0] s_ec;
`ifdef RING_DECODER_BIDIR_EN
  logic       dir, s_dir;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ring_decoder #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .ring(ring), .ring_vld(ring_vld),
    .idx(idx), .onehot_ok(ok), .locked(lk), .seq_err(se), .err_cnt(ec)
`ifdef RING_DECODER_BIDIR_EN
    , .dir(dir)
`endif
  );

  ring_decoder #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .ring(ring), .ring_vld(ring_vld),
    .idx(s_idx), .onehot_ok(s_ok), .locked(s_lk), .seq_err(s_se), .err_cnt(s_ec)
`ifdef RING_DECODER_BIDIR_EN
    , .dir(s_dir)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sample, then look at outputs 1 time unit after the edge.
  task automatic cyc(input logic [3:0] r, input logic v);
    ring     = r;
    ring_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string tag, input int e_idx, input int e_ok,
                         input int e_lk, input int e_se, input int e_ec);
    chk({tag, ".idx"},     int'(idx), e_idx);
    chk({tag, ".ok"},      int'(ok),  e_ok);
    chk({tag, ".locked"},  int'(lk),  e_lk);
    chk({tag, ".seq_err"}, int'(se),  e_se);
    chk({tag, ".err_cnt"}, int'(ec),  e_ec);
  endtask

  initial begin
    // Reset for two cycles
    rst = 1'b0;
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    exp_out("rst", 0, 0, 0, 0, 0);
    chk("rst.sat_err", int'(s_ec), 0);
    rst = 1'b1;

    // Lock from reset
    cyc(4'b0001, 1'b1); exp_out("lock0", 0, 1, 0, 0, 0);
    cyc(4'b1000, 1'b1); exp_out("lock1", 3, 1, 0, 0, 0);
    cyc(4'b0100, 1'b1); exp_out("lock2", 2, 1, 1, 0, 0);

    // Illegal word while locked
    cyc(4'b0011, 1'b1); exp_out("illeg", 2, 0, 0, 1, 1);
    cyc(4'b0001, 1'b1); exp_out("rel0", 0, 1, 0, 0, 1);
    cyc(4'b1000, 1'b1); exp_out("rel1", 3, 1, 0, 0, 1);
    cyc(4'b0100, 1'b1); exp_out("rel2", 2, 1, 1, 0, 1);

    // Wrong order while locked; relock from prev=1000 proves prev was taken
    cyc(4'b1000, 1'b1); exp_out("order", 3, 1, 0, 1, 2);
    cyc(4'b0100, 1'b1); exp_out("ord1", 2, 1, 0, 0, 2);
    cyc(4'b0010, 1'b1); exp_out("ord2", 1, 1, 1, 0, 2);

    // ring_vld gap with garbage
    for (int g = 0; g < 3; g++) begin
      cyc(4'b1111, 1'b0); exp_out("gap", 1, 1, 1, 0, 2);
    end
    cyc(4'b0001, 1'b1); exp_out("gapnext", 0, 1, 1, 0, 2);

    // More errors: saturate the ERR_W=2 instance
    cyc(4'b0001, 1'b1); exp_out("err3", 0, 1, 0, 1, 3);
    chk("sat3", int'(s_ec), 3);
    cyc(4'b1000, 1'b1);
    cyc(4'b0100, 1'b1); chk("lk3", int'(lk), 1);
    cyc(4'b0100, 1'b1); exp_out("err4", 2, 1, 0, 1, 4);
    chk("sat4", int'(s_ec), 3);
    cyc(4'b0010, 1'b1);
    cyc(4'b0001, 1'b1); chk("lk4", int'(lk), 1);
    cyc(4'b0000, 1'b1); exp_out("err5", 0, 0, 0, 1, 5);
    chk("sat5", int'(s_ec), 3);
    chk("sat5.se", int'(s_se), 1);
    cyc(4'b0001, 1'b1);
    cyc(4'b1000, 1'b1);
    cyc(4'b0100, 1'b1); exp_out("lk5", 2, 1, 1, 0, 5);
    chk("sat.lk5", int'(s_lk), 1);

    // Reset mid-lock with an error word pending
    rst = 1'b0;
    cyc(4'b0011, 1'b1); exp_out("midrst", 0, 0, 0, 0, 0);
    chk("midrst.sat_err", int'(s_ec), 0);
    chk("midrst.sat_lk",  int'(s_lk), 0);
    rst = 1'b1;

    // Left-rotation sequence
    cyc(4'b0001, 1'b1);
    cyc(4'b0010, 1'b1);
    cyc(4'b0100, 1'b1);
`ifdef RING_DECODER_BIDIR_EN
    exp_out("bidir", 2, 1, 1, 0, 0);
    chk("bidir.dir", int'(dir), 1);
    cyc(4'b0010, 1'b1); exp_out("bidir.rev", 1, 1, 0, 1, 1);
    chk("bidir.dir2", int'(dir), 1);
`else
    exp_out("leftseq", 2, 1, 0, 0, 0);
    cyc(4'b1000, 1'b1); exp_out("leftseq2", 3, 1, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
